// File: rtl/arm7_pkg.sv
// arm7_pkg: shared width, PC register index and LDM writeback FSM states
package arm7_pkg;
  localparam int N = 32;
  localparam logic [3:0] REG_PC = 4'd15;
  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;
endpackage

// File: rtl/ldm_writeback_if.sv
// ldm_writeback_if: request, load-data and register-file write bundle for ldm_writeback
//   request : start, reg_list, base_reg, base_wb, new_base
//   load    : mem_valid, mem_data, mem_ready
//   writes  : wr_en/wr_addr/wr_data, wr_en2/wr_addr2/wr_data2, pc_write/pc_update
//   status  : busy, done
interface ldm_writeback_if #(parameter int N = arm7_pkg::N);
  logic start;
  logic [15:0] reg_list;
  logic [3:0] base_reg;
  logic base_wb;
  logic [N-1:0] new_base;
  logic mem_valid;
  logic [N-1:0] mem_data;
  logic mem_ready;
  logic wr_en;
  logic [3:0] wr_addr;
  logic [N-1:0] wr_data;
  logic wr_en2;
  logic [3:0] wr_addr2;
  logic [N-1:0] wr_data2;
  logic pc_write;
  logic [N-1:0] pc_update;
  logic busy;
  logic done;
  modport slave (
    input start, reg_list, base_reg, base_wb, new_base, mem_valid, mem_data,
    output mem_ready, wr_en, wr_addr, wr_data, wr_en2, wr_addr2, wr_data2, pc_write, pc_update, busy, done
  );
  modport master (
    output start, reg_list, base_reg, base_wb, new_base, mem_valid, mem_data,
    input mem_ready, wr_en, wr_addr, wr_data, wr_en2, wr_addr2, wr_data2, pc_write, pc_update, busy, done
  );
endinterface

// File: rtl/prio_enc16.sv
// prio_enc16: index of the lowest set bit of a 16-bit mask
//   mask : input mask
//   idx  : lowest set bit index (0 when mask is 0)
//   any  : mask is nonzero
module prio_enc16 (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        any
);
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) idx = mask[i] ? 4'(i) : idx;
  end
  assign any = |mask;
endmodule

// File: rtl/ldm_writeback.sv
// ldm_writeback: sequences load-multiple data into the register file in ascending order
//   clk, rst : clock, synchronous active-high reset
//   b        : ldm_writeback_if.slave (request, load handshake, two write ports, PC update, status)
//   LDM_WB_PC_ALIGN_EN : when defined, pc_update has bits [1:0] cleared
module ldm_writeback #(parameter int N = arm7_pkg::N) (
  input logic clk,
  input logic rst,
  ldm_writeback_if.slave b
);
  import arm7_pkg::*;
  state_t state;
  logic [15:0] mask, mask_nx;
  logic [3:0] base_r, idx;
  logic [N-1:0] base_val;
  logic wb_pend, any, load, xfer, to_pc;
  prio_enc16 u_enc (.mask(mask), .idx(idx), .any(any));
  // Outputs are gated by rst so a reset cycle itself performs no writes.
  assign load = state == LOAD && !rst;
  assign xfer = load && b.mem_valid && any;
  assign to_pc = idx == REG_PC;
  assign mask_nx = mask & ~(16'd1 << idx);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mask <= '0;
      base_r <= '0;
      base_val <= '0;
      wb_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: if (b.start) begin
          mask <= b.reg_list;
          base_r <= b.base_reg;
          base_val <= b.new_base;
          // base writeback only if the base is not overwritten by a loaded word
          wb_pend <= b.base_wb && !b.reg_list[b.base_reg];
          state <= |b.reg_list ? LOAD : FINISH;
        end
        LOAD: if (xfer) begin
          mask <= mask_nx;
          wb_pend <= 1'b0;
          state <= |mask_nx ? LOAD : FINISH;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign b.mem_ready = load;
  assign b.wr_en = xfer && !to_pc;
  assign b.wr_addr = b.wr_en ? idx : '0;
  assign b.wr_data = b.wr_en ? b.mem_data : '0;
  assign b.wr_en2 = xfer && wb_pend;
  assign b.wr_addr2 = b.wr_en2 ? base_r : '0;
  assign b.wr_data2 = b.wr_en2 ? base_val : '0;
  assign b.pc_write = xfer && to_pc;
`ifdef LDM_WB_PC_ALIGN_EN
  assign b.pc_update = b.pc_write ? {b.mem_data[N-1:2], 2'b00} : '0;
`else
  assign b.pc_update = b.pc_write ? b.mem_data : '0;
`endif
  assign b.busy = state != IDLE && !rst;
  assign b.done = state == FINISH && !rst;
endmodule

// File: tb/tb_ldm_writeback.sv
// tb_ldm_writeback: scoreboard bench for ldm_writeback with directed and random sequences
module tb_ldm_writeback;
  localparam int N = 32;
  typedef struct packed {
    logic [31:0] cyc;
    logic we;
    logic [3:0] a;
    logic [N-1:0] d;
    logic we2;
    logic [3:0] a2;
    logic [N-1:0] d2;
    logic pw;
    logic [N-1:0] pu;
    logic dn;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] cyc = '0;
  int n_chk = 0;
  int n_fail = 0;
  ev_t exp_q[$];
  ldm_writeback_if #(.N(N)) b ();
  ldm_writeback #(.N(N)) dut (.clk(clk), .rst(rst), .b(b.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] pc_exp(input logic [N-1:0] w);
`ifdef LDM_WB_PC_ALIGN_EN
    return w & ~N'(3);
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: every cycle with an enable or done pops one expected event.
  always @(negedge clk) begin
    ev_t a, e;
    a = '{cyc: cyc, we: b.wr_en, a: b.wr_addr, d: b.wr_data, we2: b.wr_en2, a2: b.wr_addr2,
          d2: b.wr_data2, pw: b.pc_write, pu: b.pc_update, dn: b.done};
    n_chk++;
    if (a.we || a.we2 || a.pw || a.dn) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event got=%h", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL event got=%h want=%h", a, e);
        end
      end
    end else if ((a.a | a.a2) != 0 || (a.d | a.d2 | a.pu) != 0) begin
      n_fail++;
      $display("FAIL idle_zero got=%h want=0", a);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seq(input logic [15:0] rl, input logic [3:0] br, input logic bw,
                        input logic [N-1:0] nb, input logic [N-1:0] w0, input logic [N-1:0] w1,
                        input int max_stall);
    ev_t e;
    int k, left;
    logic [N-1:0] w;
    k = 0;
    left = $countones(rl);
    b.start = 1'b1; b.reg_list = rl; b.base_reg = br; b.base_wb = bw; b.new_base = nb;
    if (rl == 0) begin
      e = '0; e.cyc = cyc + 1; e.dn = 1'b1; exp_q.push_back(e);
    end
    step();
    b.reg_list = 16'($urandom); b.base_reg = 4'($urandom); b.base_wb = 1'($urandom); b.new_base = N'($urandom);
    for (int r = 0; r < 16; r++) if (rl[r]) begin
      repeat (max_stall > 0 ? $urandom_range(max_stall, 0) : 0) begin
        b.mem_valid = 1'b0; b.mem_data = N'($urandom); b.start = 1'($urandom);
        step();
      end
      w = k == 0 ? w0 : k == 1 ? w1 : N'($urandom);
      b.mem_valid = 1'b1; b.mem_data = w; b.start = 1'($urandom);
      e = '0; e.cyc = cyc;
      if (r == 15) begin e.pw = 1'b1; e.pu = pc_exp(w); end
      else begin e.we = 1'b1; e.a = 4'(r); e.d = w; end
      if (k == 0 && bw && !rl[br]) begin e.we2 = 1'b1; e.a2 = br; e.d2 = nb; end
      exp_q.push_back(e);
      k++;
      left--;
      if (left == 0) begin e = '0; e.cyc = cyc + 1; e.dn = 1'b1; exp_q.push_back(e); end
      @(negedge clk);
      chk("mem_ready_load", N'(b.mem_ready), N'(1));
      chk("busy_load", N'(b.busy), N'(1));
      step();
    end
    b.mem_valid = 1'b0;
    b.start = 1'b1;
    @(negedge clk);
    chk("busy_finish", N'(b.busy), N'(1));
    step();
    b.start = 1'b0;
    @(negedge clk);
    chk("busy_idle", N'(b.busy), N'(0));
    chk("mem_ready_idle", N'(b.mem_ready), N'(0));
    step();
  endtask

  initial begin
    ev_t e;
    logic [15:0] rl;
    b.start = 1'b0; b.reg_list = '0; b.base_reg = '0; b.base_wb = 1'b0; b.new_base = '0;
    b.mem_valid = 1'b0; b.mem_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", N'(b.busy), N'(0));
    chk("rst_done", N'(b.done), N'(0));
    chk("rst_mem_ready", N'(b.mem_ready), N'(0));
    step();
    do_seq(16'h0005, 4'd0, 1'b0, '0, 32'hAAAA_0001, 32'hBBBB_0002, 0);
    do_seq(16'h8001, 4'd0, 1'b0, '0, 32'h1000_0003, 32'h0000_2002, 0);
    do_seq(16'h0002, 4'd3, 1'b1, 32'h40, 32'h1111_2222, 32'h0, 0);
    do_seq(16'h0008, 4'd3, 1'b1, 32'h40, 32'h3333_4444, 32'h0, 0);
    do_seq(16'h0000, 4'd2, 1'b1, 32'h99, 32'h0, 32'h0, 0);
    do_seq(16'hFFFF, 4'd5, 1'b1, 32'h77, 32'hCAFE_0000, 32'hBEEF_0001, 0);
    do_seq(16'h8000, 4'd1, 1'b1, 32'h1234, 32'hFFFF_FFFF, 32'h0, 2);
    // Abort: stall two cycles, write R0, then reset while R1 data is offered.
    b.start = 1'b1; b.reg_list = 16'h0003; b.base_reg = 4'd0; b.base_wb = 1'b0;
    step();
    b.start = 1'b0; b.mem_valid = 1'b0;
    step();
    step();
    b.mem_valid = 1'b1; b.mem_data = 32'h5555_AAAA;
    e = '0; e.cyc = cyc; e.we = 1'b1; e.a = 4'd0; e.d = 32'h5555_AAAA;
    exp_q.push_back(e);
    step();
    rst = 1'b1; b.mem_data = 32'h6666_BBBB;
    @(negedge clk);
    chk("abort_mem_ready", N'(b.mem_ready), N'(0));
    step();
    rst = 1'b0; b.mem_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", N'(b.busy), N'(0));
    chk("abort_mem_ready_after", N'(b.mem_ready), N'(0));
    repeat (3) step();
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(4, 0))
        0: rl = 16'h0;
        1: rl = 16'h1 << $urandom_range(15, 0);
        2: rl = 16'hFFFF;
        default: rl = 16'($urandom);
      endcase
      do_seq(rl, 4'($urandom), 1'($urandom), N'($urandom), N'($urandom), N'($urandom), $urandom_range(2, 0));
    end
    repeat (3) step();
    chk("scoreboard_drained", N'(exp_q.size()), N'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
